spi_ram_responder: RTL and testbench
====================================

Name: spi_ram_responder

Overview:
- Synthesizable SPI SRAM responder (23LC1024-style subset): the target end of the RAM SPI link driven by the femto core's RAM controller (spi_clk_ram / spi_cs_n_ram / spi_mosi_ram -> spi_miso_ram).
- Oversamples the SPI pins on the system clock and serves READ (0x03) and WRITE (0x02) in sequential mode from an internal byte array.
- Used as the RAM model in integration benches and on FPGA bring-up boards.

Parameters:
- DEPTH, 4096, memory size in bytes; power of two.
- ADDR_W, 24, address bits received on the wire; always 24.

Ports:
- clk  input  1  system clock; must be >= 4x spi_clk frequency.
- reset  input  1  synchronous, active-high reset.
- spi_clk  input  1  SPI clock from the initiator, mode 0 (CPOL=0, CPHA=0).
- spi_cs_n  input  1  chip select, active low.
- spi_mosi  input  1  serial data from the initiator.
- spi_miso  output  1  serial data to the initiator.
- spi_miso_oe  output  1  1 while the responder drives MISO (READ data phase only).
- busy  output  1  1 while CS is asserted (synchronized).
- cmd_err  output  1  one-cycle pulse when an unsupported command byte completes.

Behaviour:
- Input sync: spi_clk, spi_cs_n and spi_mosi each pass through 2 flops.
  - Rise/fall of spi_clk are detected from the synced value and its delayed copy.
  - All protocol actions occur on the clk cycle in which an edge is detected.
- Reset: spi_miso=0, spi_miso_oe=0, busy=0, cmd_err=0, state=IDLE, bit counter=0, shift registers=0. Memory contents are not cleared.
- Synced CS high: forces IDLE in the same cycle from any state and clears the bit counter. A partially received write byte is discarded; bytes already committed stay. miso_oe=0.
- MOSI is sampled on each detected rising edge and shifted MSB first. An 8-bit counter tracks bits.
- States:
  - IDLE: on CS low go to CMD; busy=1.
  - CMD: after 8 bits, 0x03 or 0x02 -> ADDR with the command latched. Any other value -> IGNORE and pulse cmd_err for 1 clk.
  - ADDR: after 24 bits, latch addr = received[log2(DEPTH)-1:0]; upper bits are ignored. READ -> RD, WRITE -> WR.
  - RD:
    - On entry, load the shift-out register with mem[addr]; miso_oe=1.
    - On each detected falling edge, shift MISO to the next bit, so bit 7 appears on the first falling edge after the last address bit.
    - After each 8th rising edge, addr = addr+1 mod DEPTH and reload the shift register with mem[new addr], so the next byte's bit 7 shows on the following falling edge.
  - WR: after each 8th rising edge, write the byte to mem[addr] on that clk, then addr = addr+1 mod DEPTH.
  - IGNORE: consume clocks, no output, until CS high.
- Wrap-around: an address at DEPTH-1 followed by another byte continues at 0, for both reads and writes.
- MISO: spi_miso=0 whenever miso_oe=0. The value is registered with no combinational path from inputs.
- Latency: a pin edge is acted on 3 clk after the pin changes (2 sync + edge detect). The initiator's half-period must be >= 2 clk.
- Simultaneous events: CS rise in the same cycle as the 8th rising edge of a write byte -> CS wins and the byte is not written. Reset overrides everything.
- Reset mid-transaction: the responder returns to IDLE and stays there. A new transaction requires CS to be seen high, then low.
- Memory: a single-port array; one write per clk at most. The read for reload uses the address registered in the same cycle as the increment.

Test Plan:
- WRITE 0x02, addr 0x000010, data 0xA5 0x3C, CS high; then READ 0x03 addr 0x000010 for 2 bytes -> MISO returns 0xA5 then 0x3C; miso_oe high only during the data bytes.
- Wrap: write 0x11 to 0x000FFF and 0x22 to 0x000000 with DEPTH=4096. READ from 0xFFF for 2 bytes -> 0x11, 0x22. Also write starting at 0xFFF with 2 bytes -> second lands at 0x000.
- Upper address bits: WRITE 0x77 at 0x123010 -> READ at 0x000010 returns 0x77.
- Bad command 0x9F -> cmd_err pulses exactly 1 clk; MISO stays 0, oe stays 0 for 32 more SCK; memory unchanged.
- Abort: WRITE to 0x20 with 0x55, then 4 bits of the next byte, CS high -> mem[0x20]=0x55, mem[0x21] unchanged. Repeat with CS rise coincident with the 8th bit -> byte not written.
- Reset asserted mid-READ -> next clk spi_miso=0, oe=0, busy=0. With CS held low, no response until CS toggles high then low, after which a new READ works.

Source files
------------

// File: rtl/spi_ram_responder_if.sv
// rtl/spi_ram_responder_if.sv - RAM SPI link pins plus responder status.
interface spi_ram_responder_if;
  logic spi_clk;
  logic spi_cs_n;
  logic spi_mosi;
  logic spi_miso;
  logic spi_miso_oe;
  logic busy;
  logic cmd_err;

  modport master (
    output spi_clk, spi_cs_n, spi_mosi,
    input  spi_miso, spi_miso_oe, busy, cmd_err
  );

  modport slave (
    input  spi_clk, spi_cs_n, spi_mosi,
    output spi_miso, spi_miso_oe, busy, cmd_err
  );
endinterface

// File: rtl/spi_ram_responder.sv
// rtl/spi_ram_responder.sv - oversampled mode-0 SPI SRAM target serving sequential READ/WRITE.
module spi_ram_responder #(
  parameter int DEPTH  = 4096,
  parameter int ADDR_W = 24
) (
  input logic                 clk,
  input logic                 reset,
  spi_ram_responder_if.slave  spi
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_RD, S_WR, S_IGNORE
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      sck_q, sck_d;
  logic [1:0]      cs_q, cs_d;
  logic [1:0]      mosi_q, mosi_d;
  logic [7:0]      bit_cnt_q, bit_cnt_d;
  logic [6:0]      bits_q, bits_d;
  logic [7:0]      shift_out_q, shift_out_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            is_read_q, is_read_d;
  logic            armed_q, armed_d;
  logic            miso_q, miso_d;
  logic            oe_q, oe_d;
  logic            busy_q, busy_d;
  logic            cmd_err_q, cmd_err_d;

  logic [7:0]      mem [DEPTH];
  logic            mem_we;
  logic            rise, fall, cs_hi, mosi_bit;
  logic [7:0]      byte_in;
  logic [AW-1:0]   addr_shift, addr_inc;

  always_comb begin
    sck_d       = {sck_q[1:0], spi.spi_clk};
    cs_d        = {cs_q[0], spi.spi_cs_n};
    mosi_d      = {mosi_q[0], spi.spi_mosi};
    rise        = sck_q[1] & ~sck_q[2];
    fall        = ~sck_q[1] & sck_q[2];
    cs_hi       = cs_q[1];
    mosi_bit    = mosi_q[1];
    byte_in     = {bits_q, mosi_bit};
    addr_shift  = {addr_q[AW-2:0], mosi_bit};
    addr_inc    = addr_q + AW'(1);

    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    bits_d      = bits_q;
    shift_out_d = shift_out_q;
    addr_d      = addr_q;
    is_read_d   = is_read_q;
    miso_d      = miso_q;
    cmd_err_d   = 1'b0;
    mem_we      = 1'b0;
    // A reset leaves the responder locked out until CS has been seen high.
    armed_d     = armed_q | cs_hi;

    case (state_q)
      S_IDLE: begin
        bit_cnt_d = 8'd0;
        if (!cs_hi && armed_q) state_d = S_CMD;
      end
      S_CMD: if (rise) begin
        bits_d    = byte_in[6:0];
        bit_cnt_d = bit_cnt_q + 8'd1;
        if (bit_cnt_q == 8'd7) begin
          bit_cnt_d = 8'd0;
          if (byte_in == 8'h03 || byte_in == 8'h02) begin
            is_read_d = byte_in[0];
            state_d   = S_ADDR;
          end else begin
            cmd_err_d = 1'b1;
            state_d   = S_IGNORE;
          end
        end
      end
      S_ADDR: if (rise) begin
        // The address register doubles as the shifter, so upper wire bits fall off.
        addr_d    = addr_shift;
        bit_cnt_d = bit_cnt_q + 8'd1;
        if (bit_cnt_q == 8'd23) begin
          bit_cnt_d = 8'd0;
          if (is_read_q) begin
            shift_out_d = mem[addr_shift];
            state_d     = S_RD;
          end else begin
            state_d     = S_WR;
          end
        end
      end
      S_RD: begin
        if (fall) begin
          miso_d      = shift_out_q[7];
          shift_out_d = {shift_out_q[6:0], 1'b0};
        end
        if (rise) begin
          bit_cnt_d = bit_cnt_q + 8'd1;
          if (bit_cnt_q == 8'd7) begin
            bit_cnt_d   = 8'd0;
            addr_d      = addr_inc;
            shift_out_d = mem[addr_inc];
          end
        end
      end
      S_WR: if (rise) begin
        bits_d    = byte_in[6:0];
        bit_cnt_d = bit_cnt_q + 8'd1;
        if (bit_cnt_q == 8'd7) begin
          bit_cnt_d = 8'd0;
          mem_we    = 1'b1;
          addr_d    = addr_inc;
        end
      end
      default: ;
    endcase

    if (cs_hi) begin
      state_d   = S_IDLE;
      bit_cnt_d = 8'd0;
      mem_we    = 1'b0;
      cmd_err_d = 1'b0;
    end

    oe_d   = (state_d == S_RD);
    miso_d = oe_d ? miso_d : 1'b0;
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      sck_q       <= '0;
      cs_q        <= '0;
      mosi_q      <= '0;
      bit_cnt_q   <= '0;
      bits_q      <= '0;
      shift_out_q <= '0;
      addr_q      <= '0;
      is_read_q   <= 1'b0;
      armed_q     <= 1'b0;
      miso_q      <= 1'b0;
      oe_q        <= 1'b0;
      busy_q      <= 1'b0;
      cmd_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sck_q       <= sck_d;
      cs_q        <= cs_d;
      mosi_q      <= mosi_d;
      bit_cnt_q   <= bit_cnt_d;
      bits_q      <= bits_d;
      shift_out_q <= shift_out_d;
      addr_q      <= addr_d;
      is_read_q   <= is_read_d;
      armed_q     <= armed_d;
      miso_q      <= miso_d;
      oe_q        <= oe_d;
      busy_q      <= busy_d;
      cmd_err_q   <= cmd_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we && !reset) mem[addr_q] <= byte_in;
  end

  assign spi.spi_miso    = miso_q;
  assign spi.spi_miso_oe = oe_q;
  assign spi.busy        = busy_q;
  assign spi.cmd_err     = cmd_err_q;

endmodule

// File: tb/tb_spi_ram_responder.sv
// tb/tb_spi_ram_responder.sv - directed SPI transactions with a MISO byte scoreboard.
module tb_spi_ram_responder;

  localparam int HALF = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  spi_ram_responder_if bus ();

  spi_ram_responder #(.DEPTH(4096), .ADDR_W(24)) dut (
    .clk   (clk),
    .reset (reset),
    .spi   (bus.slave)
  );

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] exp_q[$];
  int         oe_bits = 0;
  int         err_cycles = 0;
  int         out_cycles = 0;
  logic [7:0] mon_sh = 8'h00;
  int         mon_n = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: assemble MISO bits at SCK rise while the responder drives, then score.
  initial begin
    forever begin
      @(posedge bus.spi_clk or posedge bus.spi_cs_n);
      if (bus.spi_cs_n) begin
        mon_n = 0;
      end else if (bus.spi_miso_oe) begin
        oe_bits++;
        mon_sh = {mon_sh[6:0], bus.spi_miso};
        mon_n++;
        if (mon_n == 8) begin
          mon_n = 0;
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL rd_unexpected: got %02h expected no byte", mon_sh);
          end else begin
            check("rd_byte", {24'd0, mon_sh}, {24'd0, exp_q.pop_front()});
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (bus.cmd_err) err_cycles++;
      if (bus.spi_miso || bus.spi_miso_oe) out_cycles++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sck_bit(input logic b);
    bus.spi_mosi = b;
    wait_clk(HALF);
    bus.spi_clk = 1'b1;
    wait_clk(HALF);
    bus.spi_clk = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) sck_bit(v[i]);
  endtask

  task automatic send_addr(input logic [23:0] a);
    send_byte(a[23:16]);
    send_byte(a[15:8]);
    send_byte(a[7:0]);
  endtask

  task automatic cs_begin();
    bus.spi_cs_n = 1'b0;
    wait_clk(HALF);
  endtask

  task automatic cs_end();
    wait_clk(HALF);
    bus.spi_cs_n = 1'b1;
    wait_clk(4 * HALF);
  endtask

  task automatic spi_write(input logic [23:0] a, input logic [7:0] d0, input logic [7:0] d1, input int n);
    cs_begin();
    send_byte(8'h02);
    send_addr(a);
    send_byte(d0);
    if (n > 1) send_byte(d1);
    cs_end();
  endtask

  task automatic spi_read(input logic [23:0] a, input int n);
    cs_begin();
    send_byte(8'h03);
    send_addr(a);
    repeat (n) send_byte(8'h00);
    cs_end();
    check("scoreboard_drained", exp_q.size(), 0);
  endtask

  int o0, e0, u0;
  logic [7:0] pat;

  initial begin
    reset = 1'b1;
    bus.spi_cs_n = 1'b1;
    bus.spi_clk  = 1'b0;
    bus.spi_mosi = 1'b0;
    wait_clk(3);
    check("rst_miso", bus.spi_miso, 0);
    check("rst_oe", bus.spi_miso_oe, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_cmd_err", bus.cmd_err, 0);
    reset = 1'b0;
    wait_clk(4);

    spi_write(24'h000010, 8'hA5, 8'h3C, 2);
    o0 = oe_bits;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h3C);
    spi_read(24'h000010, 2);
    check("oe_data_bits_only", oe_bits - o0, 16);
    check("idle_busy", bus.busy, 0);

    spi_write(24'h000FFF, 8'h11, 8'h00, 1);
    spi_write(24'h000000, 8'h22, 8'h00, 1);
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    spi_read(24'h000FFF, 2);
    spi_write(24'h000FFF, 8'h33, 8'h44, 2);
    exp_q.push_back(8'h44);
    spi_read(24'h000000, 1);
    exp_q.push_back(8'h33);
    spi_read(24'h000FFF, 1);

    spi_write(24'h123010, 8'h77, 8'h00, 1);
    exp_q.push_back(8'h77);
    exp_q.push_back(8'h3C);
    spi_read(24'h000010, 2);

    e0 = err_cycles;
    u0 = out_cycles;
    cs_begin();
    send_byte(8'h9F);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h10);
    send_byte(8'hEE);
    cs_end();
    check("cmd_err_width", err_cycles - e0, 1);
    check("ignore_no_output", out_cycles - u0, 0);
    exp_q.push_back(8'h77);
    spi_read(24'h000010, 1);

    spi_write(24'h000021, 8'h99, 8'h00, 1);
    cs_begin();
    send_byte(8'h02);
    send_addr(24'h000020);
    send_byte(8'h55);
    sck_bit(1'b1);
    sck_bit(1'b0);
    sck_bit(1'b1);
    sck_bit(1'b0);
    cs_end();
    exp_q.push_back(8'h55);
    exp_q.push_back(8'h99);
    spi_read(24'h000020, 2);

    spi_write(24'h000030, 8'h44, 8'h00, 1);
    pat = 8'hEE;
    cs_begin();
    send_byte(8'h02);
    send_addr(24'h000030);
    for (int i = 7; i >= 1; i--) sck_bit(pat[i]);
    bus.spi_mosi = pat[0];
    wait_clk(HALF);
    bus.spi_clk  = 1'b1;
    bus.spi_cs_n = 1'b1;
    wait_clk(HALF);
    bus.spi_clk  = 1'b0;
    wait_clk(4 * HALF);
    exp_q.push_back(8'h44);
    spi_read(24'h000030, 1);

    cs_begin();
    send_byte(8'h03);
    send_addr(24'h000010);
    sck_bit(1'b0);
    sck_bit(1'b0);
    sck_bit(1'b0);
    reset = 1'b1;
    wait_clk(1);
    check("midrd_rst_miso", bus.spi_miso, 0);
    check("midrd_rst_oe", bus.spi_miso_oe, 0);
    check("midrd_rst_busy", bus.busy, 0);
    reset = 1'b0;
    o0 = oe_bits;
    send_byte(8'h03);
    send_addr(24'h000010);
    send_byte(8'h00);
    check("lockout_oe_bits", oe_bits - o0, 0);
    check("lockout_busy", bus.busy, 0);
    cs_end();
    exp_q.push_back(8'h77);
    spi_read(24'h000010, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
